// File: rtl/udp_tx_sched.sv
// Round-robin transmit scheduler sharing one udp_tx engine between a control channel (0)
// and a bulk channel (1), with frame parameter latching, inter-frame gap and watchdog abort.
`timescale 1ns/1ps
module udp_tx_sched #(
   parameter int IFG_CYCLES = 12,
   parameter int TIMEOUT    = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [15:0] byte_num0,
   input  logic [15:0] byte_num1,
   input  logic [47:0] des_mac0,
   input  logic [47:0] des_mac1,
   input  logic [31:0] des_ip0,
   input  logic [31:0] des_ip1,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   output logic [1:0]  gnt,
   output logic [1:0]  data_req,
   output logic [1:0]  done,
   output logic [1:0]  err,
   output logic        tx_start_en,
   output logic [15:0] tx_byte_num,
   output logic [47:0] tx_des_mac,
   output logic [31:0] tx_des_ip,
   output logic [31:0] tx_data,
   input  logic        tx_req,
   input  logic        tx_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [31:0] WD_LAST  = 32'(TIMEOUT - 1);
   localparam logic [31:0] GAP_LAST = 32'(IFG_CYCLES - 1);

   state_t      state_r;
   logic        last_r;
   logic [31:0] wd_cnt_r;
   logic [31:0] gap_cnt_r;

   logic        win_valid_s;
   logic        win_s;
   logic [15:0] win_len_s;
   logic [47:0] win_mac_s;
   logic [31:0] win_ip_s;

   function automatic logic [1:0] onehot_f(input logic ch);
      onehot_f = ch ? 2'b10 : 2'b01;
   endfunction

   // Round-robin winner selection: on a tie the channel other than last_r wins.
   always_comb begin
      win_valid_s = |req;
      win_s       = 1'b0;
      if (req == 2'b11) begin
         win_s = ~last_r;
      end else if (req[1]) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
      win_len_s = win_s ? byte_num1 : byte_num0;
      win_mac_s = win_s ? des_mac1  : des_mac0;
      win_ip_s  = win_s ? des_ip1   : des_ip0;
   end

   // Engine data path follows the registered grant with no added latency.
   always_comb begin
      data_req = 2'b00;
      tx_data  = 32'h0000_0000;
      if (state_r == BUSY) begin
         data_req = gnt & {2{tx_req}};
      end else begin
         data_req = 2'b00;
      end
      if (gnt[1]) begin
         tx_data = data1;
      end else if (gnt[0]) begin
         tx_data = data0;
      end else begin
         tx_data = 32'h0000_0000;
      end
   end

   // Scheduler FSM with registered grant, strobes and latched frame parameters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         last_r      <= 1'b1;
         wd_cnt_r    <= 32'd0;
         gap_cnt_r   <= 32'd0;
         gnt         <= 2'b00;
         done        <= 2'b00;
         err         <= 2'b00;
         tx_start_en <= 1'b0;
         tx_byte_num <= 16'd0;
         tx_des_mac  <= 48'd0;
         tx_des_ip   <= 32'd0;
      end else begin
         done        <= 2'b00;
         err         <= 2'b00;
         tx_start_en <= 1'b0;
         case (state_r)
            IDLE: begin
               if (win_valid_s) begin
                  tx_byte_num <= win_len_s;
                  tx_des_mac  <= win_mac_s;
                  tx_des_ip   <= win_ip_s;
                  if (win_len_s == 16'd0) begin
                     // Nothing to send: acknowledge straight away without touching the engine.
                     done      <= onehot_f(win_s);
                     last_r    <= win_s;
                     gap_cnt_r <= 32'd0;
                     state_r   <= GAP;
                  end else begin
                     gnt         <= onehot_f(win_s);
                     tx_start_en <= 1'b1;
                     state_r     <= START;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            START: begin
               wd_cnt_r <= 32'd0;
               state_r  <= BUSY;
            end
            BUSY: begin
               if (tx_done) begin
                  done      <= gnt;
                  gnt       <= 2'b00;
                  last_r    <= gnt[1];
                  gap_cnt_r <= 32'd0;
                  state_r   <= GAP;
               end else if (wd_cnt_r == WD_LAST) begin
                  err       <= gnt;
                  gnt       <= 2'b00;
                  last_r    <= gnt[1];
                  gap_cnt_r <= 32'd0;
                  state_r   <= GAP;
               end else begin
                  wd_cnt_r <= wd_cnt_r + 32'd1;
               end
            end
            GAP: begin
               if (gap_cnt_r == GAP_LAST) begin
                  state_r <= IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + 32'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               gnt     <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: arbitration, gap, zero-length, watchdog, latching and reset.
`timescale 1ns/1ps
module tb_udp_tx_sched;
   localparam int IFG = 12;
   localparam int TO  = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [15:0] byte_num0 = 16'd0, byte_num1 = 16'd0;
   logic [47:0] des_mac0 = 48'd0, des_mac1 = 48'd0;
   logic [31:0] des_ip0 = 32'd0, des_ip1 = 32'd0;
   logic [31:0] data0 = 32'd0, data1 = 32'd0;
   logic [1:0]  gnt, data_req, done, err;
   logic        tx_start_en;
   logic [15:0] tx_byte_num;
   logic [47:0] tx_des_mac;
   logic [31:0] tx_des_ip, tx_data;
   logic        tx_req = 1'b0, tx_done = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   udp_tx_sched #(.IFG_CYCLES(IFG), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .byte_num0(byte_num0), .byte_num1(byte_num1),
      .des_mac0(des_mac0), .des_mac1(des_mac1),
      .des_ip0(des_ip0), .des_ip1(des_ip1),
      .data0(data0), .data1(data1),
      .gnt(gnt), .data_req(data_req), .done(done), .err(err),
      .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
      .tx_des_mac(tx_des_mac), .tx_des_ip(tx_des_ip), .tx_data(tx_data),
      .tx_req(tx_req), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc = cyc + 1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int s_cyc;
      int done_cyc;
      logic seen;
      logic [1:0] order [3];
      order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01;
      done_cyc = 0;

      // Reset: every output at zero even with live payload on the inputs
      data0 = 32'hDEAD_BEEF;
      tick(); tick();
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_start", 64'(tx_start_en), 64'h0);
      chk("rst_done_err", 64'({done, err}), 64'h0);
      chk("rst_params", 64'(tx_byte_num) | 64'(tx_des_ip) | 64'(tx_des_mac), 64'h0);
      chk("rst_tx_data", 64'(tx_data), 64'h0);
      rst_n = 1'b1;

      // Single request on channel 0
      byte_num0 = 16'd64; des_ip0 = 32'hC0A8_0166; des_mac0 = 48'h0011_2233_4455;
      req = 2'b01;
      tick();
      chk("single_gnt", 64'(gnt), 64'h1);
      chk("single_start", 64'(tx_start_en), 64'h1);
      chk("single_len", 64'(tx_byte_num), 64'd64);
      chk("single_ip", 64'(tx_des_ip), 64'hC0A8_0166);
      chk("single_mac", 64'(tx_des_mac), 64'h0011_2233_4455);
      tick();
      chk("single_start_off", 64'(tx_start_en), 64'h0);
      chk("single_dreq_idle", 64'(data_req), 64'h0);
      tx_req = 1'b1; data0 = 32'hA5A5_0001; #1;
      chk("single_dreq", 64'(data_req), 64'h1);
      chk("single_data", 64'(tx_data), 64'hA5A5_0001);
      tx_req = 1'b0; tx_done = 1'b1;
      tick();
      tx_done = 1'b0; req = 2'b00;
      chk("single_done", 64'(done), 64'h1);
      chk("single_gnt_clr", 64'(gnt), 64'h0);
      tick();
      chk("single_done_pulse", 64'(done), 64'h0);
      repeat (IFG + 1) tick();

      // Zero-length request on channel 1
      byte_num1 = 16'd0; req = 2'b10;
      tick();
      chk("zero_done", 64'(done), 64'h2);
      chk("zero_gnt", 64'(gnt), 64'h0);
      req = 2'b00;
      seen = tx_start_en | (|gnt);
      for (int i = 0; i < IFG + 2; i++) begin
         tick();
         seen = seen | tx_start_en | (|gnt);
      end
      chk("zero_no_start", 64'(seen), 64'h0);

      // Contention: both requesting continuously, engine finishes after 20 cycles
      byte_num0 = 16'd100; byte_num1 = 16'd200; req = 2'b11;
      for (int f = 0; f < 3; f++) begin
         n = 0;
         while (!tx_start_en && n < 40) begin
            tick();
            n = n + 1;
         end
         chk("cont_start_seen", 64'(n < 40), 64'h1);
         chk("cont_order", 64'(gnt), 64'(order[f]));
         if (f > 0) chk("cont_gap", 64'(cyc - done_cyc >= IFG + 1), 64'h1);
         repeat (20) tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         chk("cont_done", 64'(done), 64'(order[f]));
         done_cyc = cyc;
      end
      req = 2'b00;
      repeat (IFG + 2) tick();

      // Watchdog: engine never completes
      byte_num0 = 16'd10; req = 2'b01;
      tick();
      chk("wd_start", 64'(tx_start_en), 64'h1);
      s_cyc = cyc;
      seen = 1'b0;
      n = 0;
      while (err == 2'b00 && n < 200) begin
         tick();
         n = n + 1;
         seen = seen | (|done);
      end
      chk("wd_err", 64'(err), 64'h1);
      chk("wd_latency", 64'(cyc - s_cyc), 64'(TO + 1));
      chk("wd_no_done", 64'(seen), 64'h0);
      chk("wd_gnt_clr", 64'(gnt), 64'h0);
      req = 2'b10; byte_num1 = 16'd5;
      n = 0;
      while (!tx_start_en && n < 30) begin
         tick();
         n = n + 1;
      end
      chk("wd_next_start", 64'(n < 30), 64'h1);
      chk("wd_next_gnt", 64'(gnt), 64'h2);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0; req = 2'b00;
      chk("wd_next_done", 64'(done), 64'h2);
      repeat (IFG + 2) tick();

      // Parameter stability during channel 0 BUSY
      byte_num0 = 16'd300; data0 = 32'h1111_1111; data1 = 32'h2222_2222; req = 2'b01;
      tick(); tick();
      byte_num0 = 16'd7; des_ip0 = 32'h0A00_0001; data1 = 32'h3333_3333; #1;
      chk("stab_len", 64'(tx_byte_num), 64'd300);
      chk("stab_ip", 64'(tx_des_ip), 64'hC0A8_0166);
      chk("stab_data", 64'(tx_data), 64'h1111_1111);
      data0 = 32'h4444_4444; tx_req = 1'b1; #1;
      chk("stab_track", 64'(tx_data), 64'h4444_4444);
      chk("stab_dreq", 64'(data_req), 64'h1);

      // Reset mid-frame, then a tie goes to channel 0
      rst_n = 1'b0;
      tick();
      chk("mrst_gnt", 64'(gnt), 64'h0);
      chk("mrst_dreq", 64'(data_req), 64'h0);
      chk("mrst_data", 64'(tx_data), 64'h0);
      chk("mrst_params", 64'(tx_byte_num) | 64'(tx_des_ip) | 64'(tx_des_mac), 64'h0);
      chk("mrst_strobes", 64'({done, err, tx_start_en}), 64'h0);
      rst_n = 1'b1; tx_req = 1'b0;
      byte_num0 = 16'd8; byte_num1 = 16'd9; req = 2'b11;
      tick();
      chk("mrst_tie_gnt", 64'(gnt), 64'h1);
      chk("mrst_tie_len", 64'(tx_byte_num), 64'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/udp_tx_sched.md
# udp_tx_sched

Transmit scheduler that shares the single UDP transmit engine (`udp_tx` with its CRC32 companion) between two requesters: channel 0 (control/status replies) and channel 1 (bulk video/data return). It sits between the user logic and the `udp` wrapper's transmit port group. It arbitrates round-robin and latches the winner's length and destination. It issues the one-cycle start pulse and routes the engine's data-request/data path to the winner. It enforces an inter-frame gap and recovers from a hung engine with a watchdog.

## Interface
Parameters:
- `IFG_CYCLES`, default 12: idle cycles enforced after every completion/abort (≥1).
- `TIMEOUT`, default 65535: maximum cycles from start pulse to `tx_done` before abort (≥2).

Ports:
- `clk` in 1: single clock (the GMII transmit clock); all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 2: per-channel request; bit i = channel i; held high until `done[i]` or `err[i]`.
- `byte_num0`, `byte_num1` in 16 each: payload length in bytes.
- `des_mac0`, `des_mac1` in 48 each: destination MAC.
- `des_ip0`, `des_ip1` in 32 each: destination IP.
- `data0`, `data1` in 32 each: payload word supplied in response to `data_req[i]`.
- `gnt` out 2: one-hot grant, high from arbitration until completion/abort.
- `data_req` out 2: `tx_req` routed to the granted channel.
- `done` out 2: one-cycle completion pulse.
- `err` out 2: one-cycle abort pulse (watchdog).
- `tx_start_en` out 1: one-cycle start to engine.
- `tx_byte_num` out 16, `tx_des_mac` out 48, `tx_des_ip` out 32: latched parameters to engine.
- `tx_data` out 32: payload muxed from the granted channel.
- `tx_req` in 1: engine data request.
- `tx_done` in 1: engine completion pulse.

## Operation
- States: IDLE, START, BUSY, GAP.
- IDLE: if `req` non-zero, choose winner. When both are requesting, the winner is the channel ≠ `last` (round-robin pointer, reset 1, so channel 0 wins first tie). A single requester always wins.
  - Arbitration is registered. The next cycle has `gnt` one-hot, and `tx_byte_num`/`tx_des_mac`/`tx_des_ip` hold the winner's values.
  - Zero-length request (`byte_num`=0): no grant, no start. Pulse `done[w]` next cycle, set `last`=w, go to GAP.
  - Otherwise go to START.
- START: `tx_start_en`=1 for exactly this cycle; load watchdog counter to 0; go to BUSY.
- BUSY:
  - `data_req[w]` = `tx_req`. `tx_data` = `data_w`, combinational mux on registered `gnt`. The non-granted channel sees `data_req`=0.
  - Counter increments each cycle.
  - `tx_done`=1: pulse `done[w]` (registered, next cycle), clear `gnt`, set `last`=w, go to GAP.
  - Counter reaches `TIMEOUT`-1 without `tx_done`: pulse `err[w]`, clear `gnt`, set `last`=w, go to GAP.
  - `tx_done` on the same cycle as timeout: done wins, no `err`.
- GAP: count `IFG_CYCLES` cycles while ignoring `req`, then go to IDLE. This also masks the stale `req` a requester holds during the cycle it sees `done`.
- Parameters are latched once per frame; changes on `byte_num*`/`des_*` after grant do not affect the frame in flight.
- `req[w]` dropping during START/BUSY is ignored; the frame completes normally.
- `tx_done`/`tx_req` in IDLE, GAP or START are ignored. `data_req` is 0 outside BUSY.
- Reset (any state, including mid-frame): state IDLE, `last`=1, counters 0. All outputs 0: `gnt`, `data_req`, `done`, `err`, `tx_start_en`, `tx_byte_num`, `tx_des_mac`, `tx_des_ip`, `tx_data`. The engine is reset by the same `rst_n`.

## Timing
- `req` rises in IDLE at cycle N:
  - `gnt` and latched parameters at N+1.
  - `tx_start_en` high during N+1 (START).
  - BUSY from N+2.
- `tx_done` at cycle M: `done` pulse and `gnt`=0 at M+1. GAP for cycles M+1 … M+IFG_CYCLES; earliest next grant at M+IFG_CYCLES+2.
- `data_req`→`tx_data` path has zero latency (combinational through the mux); the requester must present data with the same timing it would give `udp_tx` directly.
- Watchdog abort: `err` at cycle S+TIMEOUT+1, where S is the START cycle.

## Test plan
- Single request: `req`=01, `byte_num0`=64, `des_ip0`=C0A80166 -> `gnt`=01 and `tx_start_en` one cycle later. `tx_byte_num`=64, `tx_des_ip`=C0A80166. `data_req[0]` mirrors `tx_req`. `done[0]` one cycle after `tx_done`.
- Contention: `req`=11 continuously, 3 frames, engine model finishes each after 20 cycles -> grant order 0,1,0. Each gap between completion and next `tx_start_en` is ≥ IFG_CYCLES+1.
- Zero length: `req`=10, `byte_num1`=0 -> `done[1]` after 1 cycle. `tx_start_en` never asserts and `gnt` stays 00.
- Watchdog: `TIMEOUT`=100, engine never asserts `tx_done` -> `err[0]` exactly 101 cycles after START. `done` stays 0 and the next request is served after the gap.
- Parameter stability: change `byte_num0` and `data1` during BUSY of channel 0 -> `tx_byte_num` unchanged and `tx_data` tracks only `data0`.
- Reset mid-frame: assert `rst_n`=0 in BUSY -> all outputs 0 on the next edge. After release, a tie `req`=11 grants channel 0.
